// File: rtl/ifu_ibuf_pkg.sv
// ifu_ibuf_pkg: shared core widths and encodings used by the fetch/decode boundary.
package ifu_ibuf_pkg;
  localparam int PC_WIDTH = 32;
  localparam int INST_WIDTH = 32;
  localparam logic [31:0] NOP = 32'h00000013;
endpackage

// File: rtl/ifu_ibuf.sv
// ifu_ibuf: in-order instruction buffer between fetch and decode, registered head, almost-full stall.
module ifu_ibuf #(
  parameter int DEPTH = 4,
  parameter int PC_WIDTH = ifu_ibuf_pkg::PC_WIDTH,
  parameter int INST_WIDTH = ifu_ibuf_pkg::INST_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ifu_valid,
  input  logic [PC_WIDTH-1:0]        ifu_pc,
  input  logic [INST_WIDTH-1:0]      ifu_inst,
  output logic                       ibuf_stall,
  input  logic                       flush,
  output logic                       dec_valid,
  output logic [PC_WIDTH-1:0]        dec_pc,
  output logic [INST_WIDTH-1:0]      dec_inst,
  input  logic                       dec_ready,
  output logic [$clog2(DEPTH+1)-1:0] ibuf_count,
  output logic                       ibuf_overflow
);
  import ifu_ibuf_pkg::*;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [PC_WIDTH-1:0]   pc_mem [DEPTH];
  logic [INST_WIDTH-1:0] inst_mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic full, push, pop, drop;
  assign full = count == CW'(DEPTH);
  assign pop = dec_valid && dec_ready && !flush;
  assign push = ifu_valid && !flush && (!full || pop);
  assign drop = ifu_valid && !flush && !push;
  assign dec_valid = count != '0;
  assign dec_pc = pc_mem[rd_ptr];
  assign dec_inst = inst_mem[rd_ptr];
  assign ibuf_count = count;
  assign ibuf_stall = count >= CW'(DEPTH-1);
  // storage is deliberately left out of reset; only bookkeeping state is cleared
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      ibuf_overflow <= 1'b0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        pc_mem[wr_ptr] <= ifu_pc;
        inst_mem[wr_ptr] <= ifu_inst;
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
      if (drop) ibuf_overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_ifu_ibuf.sv
// tb_ifu_ibuf: directed and random stimulus against a queue-based model of the instruction buffer.
module tb_ifu_ibuf;
  import ifu_ibuf_pkg::*;
  logic clk = 1'b0;
  logic rst, ifu_valid, flush, dec_ready;
  logic [31:0] ifu_pc, ifu_inst, dec_pc, dec_inst;
  logic ibuf_stall, dec_valid, ibuf_overflow;
  logic [2:0] ibuf_count;
  int errors = 0;
  int checks = 0;
  logic [63:0] q[$];
  logic ovf;

  ifu_ibuf #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst), .ifu_valid(ifu_valid), .ifu_pc(ifu_pc), .ifu_inst(ifu_inst),
    .ibuf_stall(ibuf_stall), .flush(flush), .dec_valid(dec_valid), .dec_pc(dec_pc),
    .dec_inst(dec_inst), .dec_ready(dec_ready), .ibuf_count(ibuf_count), .ibuf_overflow(ibuf_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [63:0] h;
    check("dec_valid", 64'(dec_valid), 64'(q.size() != 0));
    check("count", 64'(ibuf_count), 64'(q.size()));
    check("stall", 64'(ibuf_stall), 64'(q.size() >= 3));
    check("overflow", 64'(ibuf_overflow), 64'(ovf));
    if (q.size() != 0) begin
      h = q[0];
      check("dec_pc", 64'(dec_pc), 64'(h[63:32]));
      check("dec_inst", 64'(dec_inst), 64'(h[31:0]));
    end
  endtask

  task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                      input logic rdy, input logic fl);
    int sz;
    logic p, u;
    ifu_valid = v; ifu_pc = pc; ifu_inst = inst; dec_ready = rdy; flush = fl;
    @(posedge clk);
    sz = q.size();
    p = sz != 0 && rdy && !fl;
    u = v && !fl && (sz < 4 || p);
    if (fl) q.delete();
    else begin
      if (p) void'(q.pop_front());
      if (u) q.push_back({pc, inst});
      if (v && !u) ovf = 1'b1;
    end
    #1;
    check_all();
  endtask

  initial begin
    ovf = 1'b0;
    rst = 1'b1; ifu_valid = 1'b0; flush = 1'b0; dec_ready = 1'b0; ifu_pc = '0; ifu_inst = '0;
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b0;
    // single push, then hold with decode not ready
    step(1'b1, 32'h10, NOP, 1'b0, 1'b0);
    repeat (3) step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    // fill to DEPTH, then one dropped push
    for (int i = 0; i < 4; i++) step(1'b1, 32'(i), 32'(i + 100), 1'b0, 1'b0);
    step(1'b1, 32'h5, 32'h55, 1'b0, 1'b0);
    // full with simultaneous push and pop
    step(1'b1, 32'h20, 32'h2020, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    // flush at count 3 with a colliding push
    step(1'b1, 32'h40, 32'h4040, 1'b1, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step(1'b1, 32'h44, 32'h4444, 1'b0, 1'b0);
    check("no_0x40", 64'(dec_pc == 32'h40), 64'(0));
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    // continuous stream wraps the pointers
    for (int i = 0; i < 10; i++) step(1'b1, 32'(i), 32'(i * 3), 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    // asynchronous reset between edges
    step(1'b1, 32'h60, 32'h6060, 1'b0, 1'b0);
    step(1'b1, 32'h61, 32'h6161, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    q.delete();
    ovf = 1'b0;
    check_all();
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 32'h70, 32'h7070, 1'b0, 1'b0);
    // random traffic
    for (int i = 0; i < 400; i++)
      step(1'($urandom), $urandom, $urandom, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
